// File: rtl/sram_array_1p_init.sv
// sram_array_1p_init: single-port masked-write SRAM with post-reset init sweep, req/gnt handshake,
// optional output register and a one-cycle read-valid strobe.
module sram_array_1p_init #(
  parameter int Depth = 128,
  parameter int Width = 312,
  parameter int DataBitsPerMask = 39,
  parameter bit OutputReg = 1'b0,
  parameter bit InitEn = 1'b1,
  parameter logic [Width-1:0] InitValue = '0,
  localparam int MaskWidth = Width / DataBitsPerMask,
  localparam int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_req_i,
  output logic                 init_done_o,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 write_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [MaskWidth-1:0] wmask_i,
  input  logic [Width-1:0]     wdata_i,
  output logic                 rvalid_o,
  output logic [Width-1:0]     rdata_o
);
  typedef enum logic {INIT, IDLE} state_e;
  state_e state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] pipe_q, rdata_q, rd_word;
  logic pipe_v_q, rvalid_q, in_range, last, wr, rd, ret;
  assign in_range = 32'(addr_i) < Depth;
  assign last = cnt_q == AddrWidth'(Depth - 1);
  assign wr = gnt_o & write_i & in_range;
  assign rd = gnt_o & ~write_i;
  // out-of-range reads still complete, returning zero
  assign rd_word = in_range ? mem_q[addr_i] : '0;
  assign ret = OutputReg ? pipe_v_q : rd;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= InitEn ? INIT : IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q == INIT ? (last ? IDLE : INIT) : (InitEn && init_req_i ? INIT : IDLE);
    cnt_d = state_q == INIT && !last ? cnt_q + 1'b1 : '0;
  end
  // a restart request wins over a same-cycle access
  always_comb begin
    init_done_o = state_q == IDLE;
    gnt_o = rst_ni && init_done_o && req_i && !(InitEn && init_req_i);
  end
  always_ff @(posedge clk_i)
    if (state_q == INIT) mem_q[cnt_q] <= InitValue;
    else if (wr)
      for (int i = 0; i < MaskWidth; i++)
        if (wmask_i[i])
          mem_q[addr_i][i*DataBitsPerMask +: DataBitsPerMask] <= wdata_i[i*DataBitsPerMask +: DataBitsPerMask];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      pipe_v_q <= 1'b0;
      pipe_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      pipe_v_q <= rd;
      if (rd) pipe_q <= rd_word;
      rvalid_q <= ret;
      if (ret) rdata_q <= OutputReg ? pipe_q : rd_word;
    end
  assign rvalid_o = rvalid_q;
  assign rdata_o = rdata_q;
endmodule

// File: tb/tb_sram_array_1p_init.sv
// tb_sram_array_1p_init: two instances (Depth 128 / latency 1 / zero init, Depth 100 / latency 2 /
// patterned init) checked against a word-array reference model.
module tb_sram_array_1p_init;
  localparam int W = 312;
  localparam logic [W-1:0] IV1 = {8{39'h2A_5A5A_5A5A}};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n[2], req[2], wr[2], ireq[2], gnt[2], rvalid[2], done[2];
  logic [6:0] addr[2];
  logic [7:0] wm[2];
  logic [W-1:0] wd[2], rd[2];
  logic [W-1:0] mdl[2][128];
  logic [W-1:0] hold[2];
  int dep[2] = '{128, 100};
  int lat[2] = '{1, 2};
  logic [W-1:0] ivl[2] = '{'0, IV1};
  int n_cmp = 0, n_bad = 0;

  sram_array_1p_init dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .init_req_i(ireq[0]), .init_done_o(done[0]),
    .req_i(req[0]), .gnt_o(gnt[0]), .write_i(wr[0]), .addr_i(addr[0]), .wmask_i(wm[0]),
    .wdata_i(wd[0]), .rvalid_o(rvalid[0]), .rdata_o(rd[0]));

  sram_array_1p_init #(.Depth(100), .OutputReg(1'b1), .InitValue(IV1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .init_req_i(ireq[1]), .init_done_o(done[1]),
    .req_i(req[1]), .gnt_o(gnt[1]), .write_i(wr[1]), .addr_i(addr[1]), .wmask_i(wm[1]),
    .wdata_i(wd[1]), .rvalid_o(rvalid[1]), .rdata_o(rd[1]));

  function automatic logic [W-1:0] lanes(logic [7:0] m);
    logic [W-1:0] r;
    for (int j = 0; j < 8; j++) r[j*39 +: 39] = {39{m[j]}};
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [319:0] t;
    for (int j = 0; j < 10; j++) t[j*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic drive(int k, logic r, logic w, logic [6:0] a, logic [7:0] m, logic [W-1:0] d);
    req[k] = r; wr[k] = w; addr[k] = a; wm[k] = m; wd[k] = d;
  endtask

  task automatic model_write(int k, logic [6:0] a, logic [7:0] m, logic [W-1:0] d);
    if (a < dep[k]) mdl[k][a] = (mdl[k][a] & ~lanes(m)) | (d & lanes(m));
  endtask

  task automatic test_reset(int k);
    int c;
    drive(k, 1'b1, 1'b0, 7'd5, 8'h00, '0);
    ireq[k] = 1'b0;
    rst_n[k] = 1'b0;
    #3;
    n_cmp++; if (rvalid[k] !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid k=%0d got %b exp 0", k, rvalid[k]); end
    n_cmp++; if (rd[k] !== '0) begin n_bad++; $display("FAIL rst_rdata k=%0d got %h exp 0", k, rd[k]); end
    n_cmp++; if (done[k] !== 1'b0) begin n_bad++; $display("FAIL rst_done k=%0d got %b exp 0", k, done[k]); end
    n_cmp++; if (gnt[k] !== 1'b0) begin n_bad++; $display("FAIL rst_gnt k=%0d got %b exp 0", k, gnt[k]); end
    @(posedge clk); #1;
    rst_n[k] = 1'b1;
    c = 0;
    while (c < dep[k] + 8 && done[k] !== 1'b1) begin
      n_cmp++; if (gnt[k] !== 1'b0) begin n_bad++; $display("FAIL init_gnt k=%0d cyc=%0d got %b exp 0", k, c, gnt[k]); end
      @(posedge clk); #1;
      c++;
    end
    n_cmp++; if (c != dep[k]) begin n_bad++; $display("FAIL init_len k=%0d got %0d exp %0d", k, c, dep[k]); end
    req[k] = 1'b0;
    for (int a = 0; a < 128; a++) mdl[k][a] = ivl[k];
    hold[k] = '0;
  endtask

  task automatic test_read(int k);
    drive(k, 1'b1, 1'b0, 7'd5, 8'h00, '0);
    #1;
    n_cmp++; if (gnt[k] !== 1'b1) begin n_bad++; $display("FAIL rd_gnt k=%0d got %b exp 1", k, gnt[k]); end
    @(posedge clk); #1;
    req[k] = 1'b0;
    for (int j = 1; j < lat[k]; j++) begin
      n_cmp++; if (rvalid[k] !== 1'b0) begin n_bad++; $display("FAIL rd_early k=%0d got %b exp 0", k, rvalid[k]); end
      @(posedge clk); #1;
    end
    n_cmp++; if (rvalid[k] !== 1'b1) begin n_bad++; $display("FAIL rd_valid k=%0d got %b exp 1", k, rvalid[k]); end
    n_cmp++; if (rd[k] !== ivl[k]) begin n_bad++; $display("FAIL rd_data k=%0d got %h exp %h", k, rd[k], ivl[k]); end
    hold[k] = ivl[k];
    @(posedge clk); #1;
    n_cmp++; if (rvalid[k] !== 1'b0) begin n_bad++; $display("FAIL rd_strobe k=%0d got %b exp 0", k, rvalid[k]); end
    n_cmp++; if (rd[k] !== hold[k]) begin n_bad++; $display("FAIL rd_hold k=%0d got %h exp %h", k, rd[k], hold[k]); end
  endtask

  task automatic test_masked_write(int k);
    logic [W-1:0] e, d;
    e = '0; e[38:0] = '1; e[116:78] = '1;
    drive(k, 1'b1, 1'b1, 7'd3, 8'b0000_0101, '1);
    @(posedge clk); #1;
    model_write(k, 7'd3, 8'b0000_0101, '1);
    n_cmp++; if (rvalid[k] !== 1'b0) begin n_bad++; $display("FAIL wr_noresp k=%0d got %b exp 0", k, rvalid[k]); end
    drive(k, 1'b1, 1'b0, 7'd3, 8'h00, '0);
    @(posedge clk); #1;
    req[k] = 1'b0;
    for (int j = 1; j < lat[k]; j++) begin @(posedge clk); #1; end
    n_cmp++; if (rvalid[k] !== 1'b1) begin n_bad++; $display("FAIL mw_valid k=%0d got %b exp 1", k, rvalid[k]); end
    n_cmp++; if (rd[k] !== e) begin n_bad++; $display("FAIL mw_data k=%0d got %h exp %h", k, rd[k], e); end
    n_cmp++; if (rd[k] !== mdl[k][3]) begin n_bad++; $display("FAIL mw_model k=%0d got %h exp %h", k, rd[k], mdl[k][3]); end
    hold[k] = e;
    d = rnd_word();
    drive(k, 1'b1, 1'b1, 7'd3, 8'h00, d);
    @(posedge clk); #1;
    drive(k, 1'b0, 1'b0, 7'd3, 8'h00, '0);
    @(posedge clk); #1;
    n_cmp++; if (rd[k] !== hold[k]) begin n_bad++; $display("FAIL mw_hold k=%0d got %h exp %h", k, rd[k], hold[k]); end
  endtask

  task automatic test_back_to_back(int k);
    logic [W-1:0] rq[3];
    logic ev;
    int s;
    for (int i = 0; i < 3; i++) begin
      rq[i] = rnd_word();
      drive(k, 1'b1, 1'b1, 7'(i), 8'hff, rq[i]);
      @(posedge clk); #1;
      model_write(k, 7'(i), 8'hff, rq[i]);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(k, 1'b1, 1'b0, 7'(i), 8'h00, '0);
      else drive(k, i == 3, 1'b1, 7'd0, 8'hff, rnd_word());
      #1;
      if (i < 4) begin
        n_cmp++; if (gnt[k] !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt k=%0d i=%0d got %b exp 1", k, i, gnt[k]); end
      end
      @(posedge clk); #1;
      if (i == 3) model_write(k, 7'd0, 8'hff, wd[k]);
      s = i - lat[k] + 1;
      ev = s >= 0 && s < 3;
      n_cmp++; if (rvalid[k] !== ev) begin n_bad++; $display("FAIL b2b_valid k=%0d i=%0d got %b exp %b", k, i, rvalid[k], ev); end
      if (ev) hold[k] = rq[s];
      n_cmp++; if (rd[k] !== hold[k]) begin n_bad++; $display("FAIL b2b_data k=%0d i=%0d got %h exp %h", k, i, rd[k], hold[k]); end
    end
    req[k] = 1'b0;
  endtask

  task automatic test_out_of_range(int k);
    drive(k, 1'b1, 1'b1, 7'd120, 8'hff, '1);
    @(posedge clk); #1;
    drive(k, 1'b1, 1'b0, 7'd120, 8'h00, '0);
    @(posedge clk); #1;
    req[k] = 1'b0;
    for (int j = 1; j < lat[k]; j++) begin @(posedge clk); #1; end
    n_cmp++; if (rvalid[k] !== 1'b1) begin n_bad++; $display("FAIL oor_valid k=%0d got %b exp 1", k, rvalid[k]); end
    n_cmp++; if (rd[k] !== '0) begin n_bad++; $display("FAIL oor_data k=%0d got %h exp 0", k, rd[k]); end
    hold[k] = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_init_req(int k);
    logic [W-1:0] d;
    int c;
    d = rnd_word();
    drive(k, 1'b1, 1'b1, 7'd9, 8'hff, d);
    @(posedge clk); #1;
    model_write(k, 7'd9, 8'hff, d);
    drive(k, 1'b1, 1'b0, 7'd9, 8'h00, '0);
    @(posedge clk); #1;
    if (lat[k] == 1) begin
      n_cmp++; if (rd[k] !== d) begin n_bad++; $display("FAIL pre_sweep k=%0d got %h exp %h", k, rd[k], d); end
    end
    ireq[k] = 1'b1;
    #1;
    n_cmp++; if (gnt[k] !== 1'b0) begin n_bad++; $display("FAIL ireq_prio k=%0d got %b exp 0", k, gnt[k]); end
    @(posedge clk); #1;
    ireq[k] = 1'b0;
    n_cmp++; if (rvalid[k] !== (lat[k] == 2)) begin n_bad++; $display("FAIL inflight_valid k=%0d got %b exp %b", k, rvalid[k], lat[k] == 2); end
    n_cmp++; if (rd[k] !== d) begin n_bad++; $display("FAIL inflight_data k=%0d got %h exp %h", k, rd[k], d); end
    hold[k] = d;
    c = 0;
    while (c < dep[k] + 8 && done[k] !== 1'b1) begin
      ireq[k] = c == 10;
      n_cmp++; if (gnt[k] !== 1'b0) begin n_bad++; $display("FAIL sweep_gnt k=%0d cyc=%0d got %b exp 0", k, c, gnt[k]); end
      @(posedge clk); #1;
      c++;
    end
    ireq[k] = 1'b0;
    n_cmp++; if (c != dep[k]) begin n_bad++; $display("FAIL sweep_len k=%0d got %0d exp %0d", k, c, dep[k]); end
    for (int a = 0; a < 128; a++) mdl[k][a] = ivl[k];
    n_cmp++; if (gnt[k] !== 1'b1) begin n_bad++; $display("FAIL post_gnt k=%0d got %b exp 1", k, gnt[k]); end
    @(posedge clk); #1;
    req[k] = 1'b0;
    for (int j = 1; j < lat[k]; j++) begin @(posedge clk); #1; end
    n_cmp++; if (rvalid[k] !== 1'b1) begin n_bad++; $display("FAIL post_valid k=%0d got %b exp 1", k, rvalid[k]); end
    n_cmp++; if (rd[k] !== ivl[k]) begin n_bad++; $display("FAIL post_data k=%0d got %h exp %h", k, rd[k], ivl[k]); end
    hold[k] = ivl[k];
  endtask

  task automatic test_reset_mid(int k);
    drive(k, 1'b1, 1'b0, 7'd1, 8'h00, '0);
    @(posedge clk); #1;
    req[k] = 1'b0;
    rst_n[k] = 1'b0;
    #1;
    n_cmp++; if (rvalid[k] !== 1'b0) begin n_bad++; $display("FAIL arst_valid k=%0d got %b exp 0", k, rvalid[k]); end
    n_cmp++; if (done[k] !== 1'b0) begin n_bad++; $display("FAIL arst_done k=%0d got %b exp 0", k, done[k]); end
    @(posedge clk); #1;
    rst_n[k] = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (rvalid[k] !== 1'b0) begin n_bad++; $display("FAIL arst_discard k=%0d got %b exp 0", k, rvalid[k]); end
    n_cmp++; if (rd[k] !== '0) begin n_bad++; $display("FAIL arst_rdata k=%0d got %h exp 0", k, rd[k]); end
    for (int c = 1; c < 50; c++) begin @(posedge clk); #1; end
    n_cmp++; if (done[k] !== 1'b0) begin n_bad++; $display("FAIL mid_done k=%0d got %b exp 0", k, done[k]); end
    test_reset(k);
  endtask

  task automatic test_random(int k, int n);
    int due_q[$];
    logic [W-1:0] dat_q[$];
    int cyc;
    logic w;
    logic [6:0] a;
    logic [7:0] m;
    logic [W-1:0] d;
    cyc = 0;
    for (int i = 0; i < n + 3; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 7'(k == 1 ? $urandom_range(92, 123) : $urandom_range(0, 15));
      m = 8'($urandom);
      d = rnd_word();
      drive(k, i < n, w, a, m, d);
      #1;
      if (i < n) begin
        n_cmp++; if (gnt[k] !== 1'b1) begin n_bad++; $display("FAIL rnd_gnt k=%0d i=%0d got %b exp 1", k, i, gnt[k]); end
      end
      @(posedge clk);
      cyc++;
      if (i < n) begin
        if (w) model_write(k, a, m, d);
        else begin
          due_q.push_back(cyc + lat[k] - 1);
          dat_q.push_back(a < dep[k] ? mdl[k][a] : '0);
        end
      end
      #1;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        hold[k] = dat_q.pop_front();
        void'(due_q.pop_front());
        n_cmp++; if (rvalid[k] !== 1'b1) begin n_bad++; $display("FAIL rnd_valid k=%0d i=%0d got %b exp 1", k, i, rvalid[k]); end
      end else begin
        n_cmp++; if (rvalid[k] !== 1'b0) begin n_bad++; $display("FAIL rnd_idle k=%0d i=%0d got %b exp 0", k, i, rvalid[k]); end
      end
      n_cmp++; if (rd[k] !== hold[k]) begin n_bad++; $display("FAIL rnd_data k=%0d i=%0d got %h exp %h", k, i, rd[k], hold[k]); end
    end
    req[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; ireq[k] = 1'b0; hold[k] = '0;
      drive(k, 1'b0, 1'b0, 7'd0, 8'h00, '0);
    end
    test_reset(0);
    test_read(0);
    test_masked_write(0);
    test_init_req(0);
    test_random(0, 300);
    test_reset(1);
    test_read(1);
    test_back_to_back(1);
    test_out_of_range(1);
    test_init_req(1);
    test_reset_mid(1);
    test_random(1, 300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
